// File: rtl/calendar_pkg.sv
// Mode encodings for the calendar set controller, shared with the display mux.
package calendar_pkg;

   typedef enum logic [1:0] {
      MODE_RUN       = 2'b00,
      MODE_SET_DAY   = 2'b01,
      MODE_SET_MONTH = 2'b10,
      MODE_SET_YEAR  = 2'b11
   } mode_e;

   // The mode button walks RUN -> SET_DAY -> SET_MONTH -> SET_YEAR -> RUN.
   function automatic mode_e next_mode(input mode_e m);
      return mode_e'(m + 2'd1);
   endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink prescaler and idle timeout for the field being set; idle (all zero) while disabled.
module blink_timer #(
   parameter logic [23:0] BLINK_DIV    = 24'd12_500_000,
   parameter logic [7:0]  IDLE_TIMEOUT = 8'd16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic o_blink,
   output logic o_timeout
);

   localparam int PW = (BLINK_DIV > 24'd1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_DIV - 24'd1);

   logic [PW-1:0] pre_q, pre_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          blink_q, blink_d;
   logic          wrap;

   assign wrap      = enable && !clear && (pre_q == PRE_LAST);
   // The toggle that would be the IDLE_TIMEOUT-th one becomes the timeout instead.
   assign o_timeout = wrap && (cnt_q == IDLE_TIMEOUT - 8'd1);
   assign o_blink   = blink_q;

   always_comb begin
      pre_d   = pre_q + PW'(1);
      cnt_d   = cnt_q;
      blink_d = blink_q;
      if (clear || !enable || o_timeout) begin
         pre_d   = '0;
         cnt_d   = '0;
         blink_d = 1'b0;
      end else if (wrap) begin
         pre_d   = '0;
         cnt_d   = cnt_q + 8'd1;
         blink_d = ~blink_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q   <= '0;
         cnt_q   <= '0;
         blink_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
      end
   end

endmodule

// File: rtl/calendar_set_ctrl.sv
// Sequencer for the day/month/year counter chain: forwards carries in RUN,
// steps single fields in SET modes, buffers a midnight tick meanwhile.
module calendar_set_ctrl
   import calendar_pkg::*;
#(
   parameter logic [23:0] BLINK_DIV    = 24'd12_500_000,
   parameter logic [7:0]  IDLE_TIMEOUT = 8'd16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_day_tick,
   input  logic       i_day_carry,
   input  logic       i_month_carry,
   input  logic       i_btn_mode,
   input  logic       i_btn_inc,
   output logic       o_inc_day,
   output logic       o_inc_month,
   output logic       o_inc_year,
   output logic [1:0] o_mode,
   output logic       o_blink,
   output logic       o_tick_lost
);

   mode_e state_q, state_d;
   logic  pend_q, lost_q;
   logic  inc_day_q, inc_month_q, inc_year_q;
   logic  in_set, to_run, set_inc, timeout;

   blink_timer #(
      .BLINK_DIV   (BLINK_DIV),
      .IDLE_TIMEOUT(IDLE_TIMEOUT)
   ) u_blink (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (i_btn_mode | i_btn_inc),
      .enable   (in_set),
      .o_blink  (o_blink),
      .o_timeout(timeout)
   );

   assign in_set  = (state_q != MODE_RUN);
   assign to_run  = in_set && (state_d == MODE_RUN);
   assign set_inc = in_set && i_btn_inc && !i_btn_mode;

   always_comb begin
      state_d = state_q;
      if (i_btn_mode)   state_d = next_mode(state_q);
      else if (timeout) state_d = MODE_RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= MODE_RUN;
         pend_q      <= 1'b0;
         lost_q      <= 1'b0;
         inc_day_q   <= 1'b0;
         inc_month_q <= 1'b0;
         inc_year_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         inc_day_q   <= 1'b0;
         inc_month_q <= 1'b0;
         inc_year_q  <= 1'b0;
         if (!in_set) begin
            // A buffered tick goes first; a coincident new tick is deferred one cycle.
            inc_day_q   <= i_day_tick | pend_q;
            pend_q      <= pend_q & i_day_tick;
            inc_month_q <= i_day_carry;
            inc_year_q  <= i_month_carry;
         end else if (to_run) begin
            inc_day_q <= pend_q;
            pend_q    <= i_day_tick;
         end else begin
            inc_day_q   <= set_inc && (state_q == MODE_SET_DAY);
            inc_month_q <= set_inc && (state_q == MODE_SET_MONTH);
            inc_year_q  <= set_inc && (state_q == MODE_SET_YEAR);
            if (i_day_tick) begin
               if (pend_q) lost_q <= 1'b1;
               pend_q <= 1'b1;
            end
         end
      end
   end

   assign o_mode      = state_q;
   assign o_inc_day   = inc_day_q;
   assign o_inc_month = inc_month_q;
   assign o_inc_year  = inc_year_q;
   assign o_tick_lost = lost_q;

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Scoreboard bench for calendar_set_ctrl with BLINK_DIV=4, IDLE_TIMEOUT=3.
module tb_calendar_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_day_tick = 1'b0, i_day_carry = 1'b0, i_month_carry = 1'b0;
   logic       i_btn_mode = 1'b0, i_btn_inc = 1'b0;
   logic       o_inc_day, o_inc_month, o_inc_year, o_blink, o_tick_lost;
   logic [1:0] o_mode;

   typedef struct {int cyc; int kind;} exp_t;
   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   string kname[3] = '{"inc_day", "inc_month", "inc_year"};

   calendar_set_ctrl #(.BLINK_DIV(24'd4), .IDLE_TIMEOUT(8'd3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_day_tick   (i_day_tick),
      .i_day_carry  (i_day_carry),
      .i_month_carry(i_month_carry),
      .i_btn_mode   (i_btn_mode),
      .i_btn_inc    (i_btn_inc),
      .o_inc_day    (o_inc_day),
      .o_inc_month  (o_inc_month),
      .o_inc_year   (o_inc_year),
      .o_mode       (o_mode),
      .o_blink      (o_blink),
      .o_tick_lost  (o_tick_lost)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: every observed inc pulse must match the head of the queue.
   always @(negedge clk) begin
      logic [2:0] p;
      p = {o_inc_year, o_inc_month, o_inc_day};
      while (q.size() > 0 && q[0].cyc < cyc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL missing_%s: got 0 at cycle %0d, required 1", kname[q[0].kind], q[0].cyc);
         void'(q.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
         if (p[k]) begin
            n_cmp++;
            if (q.size() > 0 && q[0].cyc == cyc && q[0].kind == k) begin
               void'(q.pop_front());
            end else begin
               n_bad++;
               $display("FAIL unexpected_%s: got 1 at cycle %0d, required 0", kname[k], cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic expect_pulse(input int c, input int k);
      exp_t e;
      e.cyc  = c;
      e.kind = k;
      q.push_back(e);
   endtask

   task automatic drive(input logic dt, input logic dc, input logic mc, input logic bm, input logic bi);
      i_day_tick = dt; i_day_carry = dc; i_month_carry = mc; i_btn_mode = bm; i_btn_inc = bi;
      @(posedge clk); #1;
      i_day_tick = 0; i_day_carry = 0; i_month_carry = 0; i_btn_mode = 0; i_btn_inc = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle(2);
      rst_n = 1'b1;
      chk("reset_mode", int'(o_mode), 0);
      chk("reset_blink", int'(o_blink), 0);
      chk("reset_lost", int'(o_tick_lost), 0);
      idle(1);

      // RUN forwarding
      expect_pulse(cyc + 1, 0); drive(1, 0, 0, 0, 0);
      idle(1);
      expect_pulse(cyc + 1, 1); drive(0, 1, 0, 0, 0);
      expect_pulse(cyc + 1, 2); drive(0, 0, 1, 0, 0);
      expect_pulse(cyc + 1, 0); expect_pulse(cyc + 1, 1); drive(1, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      idle(2);
      chk("run_mode", int'(o_mode), 0);

      // Mode walk with field stepping
      drive(0, 0, 0, 1, 0); chk("walk_day", int'(o_mode), 1);
      drive(0, 1, 1, 0, 0);
      drive(0, 0, 0, 1, 0); chk("walk_month", int'(o_mode), 2);
      for (int i = 0; i < 3; i++) begin
         expect_pulse(cyc + 1, 1); drive(0, 0, 0, 0, 1);
      end
      drive(0, 0, 0, 1, 0); chk("walk_year", int'(o_mode), 3);
      expect_pulse(cyc + 1, 2); drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 1, 0); chk("walk_run", int'(o_mode), 0);
      idle(2);

      // One buffered tick, released on return to RUN
      drive(0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0);
      idle(1);
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      expect_pulse(cyc + 1, 0); drive(0, 0, 0, 1, 0);
      chk("pend_mode", int'(o_mode), 0);
      chk("pend_lost", int'(o_tick_lost), 0);
      idle(2);

      // Buffered tick plus a tick on the RUN-entering edge
      drive(0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      expect_pulse(cyc + 1, 0); expect_pulse(cyc + 2, 0); drive(1, 0, 0, 1, 0);
      idle(2);
      chk("edge_tick_lost", int'(o_tick_lost), 0);

      // Two ticks while setting: one lost, one serviced
      drive(0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      chk("lost_set", int'(o_tick_lost), 1);
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      expect_pulse(cyc + 1, 0); drive(0, 0, 0, 1, 0);
      chk("lost_sticky", int'(o_tick_lost), 1);
      idle(2);

      // Idle timeout from SET_YEAR
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      chk("to_mode0", int'(o_mode), 3);
      chk("to_blink0", int'(o_blink), 0);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         chk($sformatf("to_blink_%0d", k), int'(o_blink), (k < 12) ? ((k / 4) % 2) : 0);
         chk($sformatf("to_mode_%0d", k), int'(o_mode), (k < 12) ? 3 : 0);
      end
      idle(2);

      // Mode and inc in the same cycle
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 1);
      chk("simul_mode", int'(o_mode), 2);
      idle(2);

      // Asynchronous reset mid-SET_MONTH, between clock edges
      idle(3);
      chk("pre_rst_mode", int'(o_mode), 2);
      chk("pre_rst_blink", int'(o_blink), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mode", int'(o_mode), 0);
      chk("arst_blink", int'(o_blink), 0);
      chk("arst_lost", int'(o_tick_lost), 0);
      chk("arst_incs", int'({o_inc_day, o_inc_month, o_inc_year}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(3);
      chk("post_rst_mode", int'(o_mode), 0);

      while (q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL pending_%s: got none, required pulse at cycle %0d", kname[q[0].kind], q[0].cyc);
         void'(q.pop_front());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
